key_pair_selector: RTL and testbench

- Sits between the PS/2 keyboard decoder and the memory-game control logic.
- Turns raw make/break events into clean one-cycle game commands: PAIR (two grid cells held together), MIRROR (Shift plus a grid cell) and CONFIRM (Enter).
- Tracks the key held first, with a hold timeout. Ignores typematic repeats and cells already matched.
- Lets the game FSM consume commands without decoding scan codes.

---
 rtl/key_pair_selector.sv | 197 +++++++++++++++++++
 tb/tb_key_pair_selector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_pair_selector.sv
// Key pair selector: turns PS/2 make/break events into one-cycle PAIR, MIRROR and
// CONFIRM game commands. It tracks the first held key with a hold timeout.
module key_pair_selector #(
    parameter int TIMEOUT_CYC = 100000000,
    parameter int TW          = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable_i,
    input  logic         key_valid_i,
    input  logic [8:0]   last_change_i,
    input  logic [511:0] key_down_i,
    input  logic [15:0]  blocked_i,
    output logic         cmd_valid_o,
    output logic [1:0]   cmd_type_o,
    output logic [3:0]   cmd_a_o,
    output logic [3:0]   cmd_b_o,
    output logic [4:0]   held_key_o,
    output logic [1:0]   sel_state_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ONE = 2'd1, S_LOCKED = 2'd2} state_e;
    typedef enum logic [1:0] {CMD_PAIR = 2'd0, CMD_MIRROR = 2'd1, CMD_CONFIRM = 2'd2} cmd_e;

    localparam logic [4:0] K_SHIFT = 5'd16;
    localparam logic [4:0] K_ENTER = 5'd17;
    localparam logic [4:0] K_NONE  = 5'd18;

    function automatic logic [4:0] code_to_key(input logic [8:0] code);
        case (code)
            9'h016: return 5'd0;
            9'h01E: return 5'd1;
            9'h026: return 5'd2;
            9'h025: return 5'd3;
            9'h015: return 5'd4;
            9'h01D: return 5'd5;
            9'h024: return 5'd6;
            9'h02D: return 5'd7;
            9'h01C: return 5'd8;
            9'h01B: return 5'd9;
            9'h023: return 5'd10;
            9'h02B: return 5'd11;
            9'h01A: return 5'd12;
            9'h022: return 5'd13;
            9'h021: return 5'd14;
            9'h02A: return 5'd15;
            9'h012: return K_SHIFT;
            9'h05A: return K_ENTER;
            default: return K_NONE;
        endcase
    endfunction

    function automatic logic [8:0] key_to_code(input logic [4:0] key);
        case (key)
            5'd0:  return 9'h016;
            5'd1:  return 9'h01E;
            5'd2:  return 9'h026;
            5'd3:  return 9'h025;
            5'd4:  return 9'h015;
            5'd5:  return 9'h01D;
            5'd6:  return 9'h024;
            5'd7:  return 9'h02D;
            5'd8:  return 9'h01C;
            5'd9:  return 9'h01B;
            5'd10: return 9'h023;
            5'd11: return 9'h02B;
            5'd12: return 9'h01A;
            5'd13: return 9'h022;
            5'd14: return 9'h021;
            5'd15: return 9'h02A;
            5'd16: return 9'h012;
            default: return 9'h000;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [4:0]      k1_q, k1_d, k2_q, k2_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            cmd_valid_q, cmd_fire;
    cmd_e            cmd_type_q, cmd_type_d;
    logic [3:0]      cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;

    logic [4:0] ev_key;
    logic       is_make, is_break, cell_ok, both_released, timeout;

    assign ev_key        = code_to_key(last_change_i);
    assign is_make       = key_valid_i &&  key_down_i[last_change_i];
    assign is_break      = key_valid_i && !key_down_i[last_change_i];
    assign cell_ok       = (ev_key < 5'd16) && !blocked_i[4'd15 - ev_key[3:0]];
    assign both_released = !key_down_i[key_to_code(k1_q)] && !key_down_i[key_to_code(k2_q)];
    assign timeout       = (timer_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        k1_d       = k1_q;
        k2_d       = k2_q;
        timer_d    = '0;
        cmd_fire   = 1'b0;
        cmd_type_d = cmd_type_q;
        cmd_a_d    = 4'd0;
        cmd_b_d    = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (is_make && (cell_ok || ev_key == K_SHIFT)) begin
                    k1_d    = ev_key;
                    state_d = S_ONE;
                end else if (is_make && ev_key == K_ENTER) begin
                    cmd_fire   = 1'b1;
                    cmd_type_d = CMD_CONFIRM;
                end
            end
            S_ONE: begin
                timer_d = timer_q + 1'b1;
                if (is_make && ev_key == K_ENTER) begin
                    cmd_fire   = 1'b1;
                    cmd_type_d = CMD_CONFIRM;
                    state_d    = S_IDLE;
                end else if (is_make && ev_key != k1_q && cell_ok) begin
                    cmd_fire = 1'b1;
                    k2_d     = ev_key;
                    state_d  = S_LOCKED;
                    if (k1_q == K_SHIFT) begin
                        cmd_type_d = CMD_MIRROR;
                        cmd_a_d    = ev_key[3:0];
                    end else begin
                        cmd_type_d = CMD_PAIR;
                        cmd_a_d    = k1_q[3:0];
                        cmd_b_d    = ev_key[3:0];
                    end
                end else if (is_make && ev_key == K_SHIFT && k1_q != K_SHIFT) begin
                    cmd_fire   = 1'b1;
                    cmd_type_d = CMD_MIRROR;
                    cmd_a_d    = k1_q[3:0];
                    k2_d       = K_SHIFT;
                    state_d    = S_LOCKED;
                end else if ((is_break && ev_key == k1_q) || timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (is_make && ev_key == K_ENTER) begin
                    cmd_fire   = 1'b1;
                    cmd_type_d = CMD_CONFIRM;
                    state_d    = S_IDLE;
                end else if (both_released) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Leaving the game's play state abandons any selection and swallows the event.
        if (!enable_i) begin
            state_d  = S_IDLE;
            cmd_fire = 1'b0;
        end
        if (state_d == S_IDLE) begin
            k1_d = K_NONE;
            k2_d = K_NONE;
        end
        if (state_d != S_ONE) timer_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k1_q        <= K_NONE;
            k2_q        <= K_NONE;
            timer_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= CMD_PAIR;
            cmd_a_q     <= 4'd0;
            cmd_b_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            timer_q     <= timer_d;
            cmd_valid_q <= cmd_fire;
            if (cmd_fire) begin
                cmd_type_q <= cmd_type_d;
                cmd_a_q    <= cmd_a_d;
                cmd_b_q    <= cmd_b_d;
            end
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_type_o  = cmd_type_q;
    assign cmd_a_o     = cmd_a_q;
    assign cmd_b_o     = cmd_b_q;
    assign held_key_o  = k1_q;
    assign sel_state_o = state_q;

endmodule

// File: tb/tb_key_pair_selector.sv
// Bench for key_pair_selector: directed scenarios plus random key traffic, all
// outputs compared every cycle against an event-level model of the selection rules.
module tb_key_pair_selector;

    localparam int TIMEOUT = 20;

    logic         clk = 1'b0;
    logic         rst, enable, key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic [15:0]  blocked;
    logic         cmd_valid;
    logic [1:0]   cmd_type;
    logic [3:0]   cmd_a, cmd_b;
    logic [4:0]   held_key;
    logic [1:0]   sel_state;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    key_pair_selector #(.TIMEOUT_CYC(TIMEOUT), .TW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .key_valid_i  (key_valid),
        .last_change_i(last_change),
        .key_down_i   (key_down),
        .blocked_i    (blocked),
        .cmd_valid_o  (cmd_valid),
        .cmd_type_o   (cmd_type),
        .cmd_a_o      (cmd_a),
        .cmd_b_o      (cmd_b),
        .held_key_o   (held_key),
        .sel_state_o  (sel_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cell_codes [16] = '{'h016, 'h01E, 'h026, 'h025, 'h015, 'h01D, 'h024, 'h02D,
                            'h01C, 'h01B, 'h023, 'h02B, 'h01A, 'h022, 'h021, 'h02A};

    function automatic int key_of(input logic [8:0] code);
        for (int i = 0; i < 16; i++) if (int'(code) == cell_codes[i]) return i;
        if (code == 9'h012) return 16;
        if (code == 9'h05A) return 17;
        return 18;
    endfunction

    function automatic int code_of(input int k);
        return (k < 16) ? cell_codes[k] : 'h012;
    endfunction

    int m_sel = 0, m_k1 = 18, m_k2 = 18, m_since = 0, cyc = 0;
    int m_ct = 0, m_ca = 0, m_cb = 0;
    bit m_cv = 1'b0;

    task automatic m_emit(input int t, input int a, input int b);
        m_cv = 1'b1; m_ct = t; m_ca = a; m_cb = b;
    endtask

    task automatic m_drop();
        m_sel = 0; m_k1 = 18; m_k2 = 18;
    endtask

    // NOTE: the model updates with blocking assignments at the edge; outputs are compared on the opposite edge.
    always @(posedge clk) begin
        int k;
        bit mk, brk, usable;
        cyc++;
        m_cv = 1'b0;
        if (rst) begin
            m_drop();
            m_ct = 0; m_ca = 0; m_cb = 0;
        end else if (!enable) begin
            m_drop();
        end else begin
            k      = key_of(last_change);
            mk     = key_valid &&  key_down[last_change];
            brk    = key_valid && !key_down[last_change];
            usable = 1'b0;
            if (k < 16) usable = !blocked[15 - k];
            case (m_sel)
                0: begin
                    if (mk && (usable || k == 16)) begin
                        m_k1 = k; m_sel = 1; m_since = cyc;
                    end else if (mk && k == 17) begin
                        m_emit(2, 0, 0);
                    end
                end
                1: begin
                    if (mk && k == 17) begin
                        m_emit(2, 0, 0); m_drop();
                    end else if (mk && k != m_k1 && (usable || k == 16)) begin
                        m_k2 = k; m_sel = 2;
                        if (m_k1 == 16)   m_emit(1, k, 0);
                        else if (k == 16) m_emit(1, m_k1, 0);
                        else              m_emit(0, m_k1, k);
                    end else if (brk && k == m_k1) begin
                        m_drop();
                    end else if (cyc - m_since == TIMEOUT) begin
                        m_drop();
                    end
                end
                default: begin
                    if (mk && k == 17) begin
                        m_emit(2, 0, 0); m_drop();
                    end else if (!key_down[code_of(m_k1)] && !key_down[code_of(m_k2)]) begin
                        m_drop();
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmd_valid", 32'(cmd_valid), 32'(m_cv));
            check("sel_state", 32'(sel_state), m_sel);
            check("held_key",  32'(held_key),  m_k1);
            check("cmd_type",  32'(cmd_type),  m_ct);
            check("cmd_a",     32'(cmd_a),     m_ca);
            check("cmd_b",     32'(cmd_b),     m_cb);
        end
    end

    // ---------------- stimulus ----------------
    task automatic strobe(input logic [8:0] code, input bit down);
        @(negedge clk);
        key_down[code] = down;
        last_change    = code;
        key_valid      = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press(input logic [8:0] code);   strobe(code, 1'b1); endtask
    task automatic release_key(input logic [8:0] code); strobe(code, 1'b0); endtask

    logic [8:0] pool [20] = '{9'h016, 9'h01E, 9'h026, 9'h025, 9'h015, 9'h01D, 9'h024, 9'h02D,
                              9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h01A, 9'h022, 9'h021, 9'h02A,
                              9'h012, 9'h05A, 9'h07E, 9'h114};

    initial begin
        logic [8:0] code;
        rst = 1'b1; enable = 1'b0; key_valid = 1'b0; last_change = '0;
        key_down = '0; blocked = '0;
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        check("reset_state", 32'(sel_state), 0);
        check("reset_held",  32'(held_key),  18);
        check("reset_valid", 32'(cmd_valid), 0);
        rst = 1'b0; enable = 1'b1;

        // Pair
        press(9'h016);
        repeat (9) @(negedge clk);
        press(9'h026);
        check("pair_valid", 32'(cmd_valid), 1);
        check("pair_type",  32'(cmd_type),  0);
        check("pair_a",     32'(cmd_a),     0);
        check("pair_b",     32'(cmd_b),     2);
        check("pair_state", 32'(sel_state), 2);
        @(negedge clk);
        check("pair_pulse_end", 32'(cmd_valid), 0);
        release_key(9'h016);
        release_key(9'h026);
        check("pair_release_state", 32'(sel_state), 0);

        // Mirror, Shift first then cell first
        press(9'h012);
        check("mirror_held_shift", 32'(held_key), 16);
        press(9'h02A);
        check("mirror1_type", 32'(cmd_type), 1);
        check("mirror1_a",    32'(cmd_a),    15);
        check("mirror1_b",    32'(cmd_b),    0);
        release_key(9'h012); release_key(9'h02A);
        press(9'h01C);
        press(9'h012);
        check("mirror2_valid", 32'(cmd_valid), 1);
        check("mirror2_type",  32'(cmd_type),  1);
        check("mirror2_a",     32'(cmd_a),     8);
        release_key(9'h01C); release_key(9'h012);

        // Blocked cell and typematic repeat
        blocked = 16'h8000;
        press(9'h016);
        check("blocked_state", 32'(sel_state), 0);
        release_key(9'h016);
        press(9'h01E);
        press(9'h01E);
        check("repeat_valid", 32'(cmd_valid), 0);
        press(9'h016);
        check("blocked2_valid", 32'(cmd_valid), 0);
        check("blocked2_held",  32'(held_key),  1);
        release_key(9'h016); release_key(9'h01E);
        check("break_k1_state", 32'(sel_state), 0);
        blocked = 16'h0000;

        // Timeout expiry, then a make landing exactly on the expiry cycle
        press(9'h015);
        repeat (19) @(negedge clk);
        check("timeout_before", 32'(sel_state), 1);
        @(negedge clk);
        check("timeout_after", 32'(sel_state), 0);
        release_key(9'h015);
        press(9'h015);
        repeat (18) @(negedge clk);
        press(9'h01D);
        check("expiry_pair_valid", 32'(cmd_valid), 1);
        check("expiry_pair_a",     32'(cmd_a),     4);
        check("expiry_pair_b",     32'(cmd_b),     5);
        release_key(9'h015); release_key(9'h01D);

        // Confirm from each state
        press(9'h05A);
        check("confirm_idle_type", 32'(cmd_type), 2);
        release_key(9'h05A);
        press(9'h016);
        press(9'h05A);
        check("confirm_one_valid", 32'(cmd_valid), 1);
        check("confirm_one_state", 32'(sel_state), 0);
        release_key(9'h05A); release_key(9'h016);
        press(9'h016); press(9'h026);
        press(9'h05A);
        check("confirm_lock_type",  32'(cmd_type),  2);
        check("confirm_lock_state", 32'(sel_state), 0);
        release_key(9'h05A); release_key(9'h016); release_key(9'h026);

        // enable dropped alongside a pair-forming make
        press(9'h016);
        @(negedge clk);
        enable = 1'b0;
        key_down[9'h026] = 1'b1; last_change = 9'h026; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("disable_valid", 32'(cmd_valid), 0);
        check("disable_state", 32'(sel_state), 0);
        enable = 1'b1;
        release_key(9'h016); release_key(9'h026);

        // Random traffic: busy and quiet stretches, with occasional disable, mask change and reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            key_valid = 1'b0;
            rst       = (i == 1500);
            enable    = ($urandom_range(0, 99) >= 3);
            if ($urandom_range(0, 99) < 5) blocked = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, ((i / 250) % 2 == 1) ? 39 : 3) == 0) begin
                code = pool[$urandom_range(0, 19)];
                if (key_down[code] && $urandom_range(0, 2) != 0) key_down[code] = 1'b0;
                else                                              key_down[code] = 1'b1;
                last_change = code;
                key_valid   = 1'b1;
            end
        end
        @(negedge clk);
        key_valid = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
